// File: rtl/fd_skid_reg_if.sv
// Fetch->decode handshake bundle: fetch-side push, decode-side head view, and the flush from execute.
interface fd_skid_reg_if #(
   parameter int XLEN = 32,
   parameter int ILEN = 32
);
   logic            flush;
   logic            f_valid;
   logic            f_ready;
   logic [ILEN-1:0] f_instr;
   logic [XLEN-1:0] f_pc;
   logic [XLEN-1:0] f_pc4;
   logic            d_valid;
   logic            d_ready;
   logic [ILEN-1:0] d_instr;
   logic [XLEN-1:0] d_pc;
   logic [XLEN-1:0] d_pc4;
   logic [2:0]      d_immsrc;

   modport slave (
      input  flush, f_valid, f_instr, f_pc, f_pc4, d_ready,
      output f_ready, d_valid, d_instr, d_pc, d_pc4, d_immsrc
   );

   modport master (
      output flush, f_valid, f_instr, f_pc, f_pc4, d_ready,
      input  f_ready, d_valid, d_instr, d_pc, d_pc4, d_immsrc
   );
endinterface

// File: rtl/fd_skid_reg.sv
// Fetch->decode register with a 2-entry skid FIFO; f_ready is registered so decode stalls never
// reach fetch combinationally. Entry 0 (_p0) is the head, entry 1 (_p1) the skid slot.
module fd_skid_reg #(
   parameter int              XLEN = 32,
   parameter int              ILEN = 32,
   parameter logic [ILEN-1:0] NOP  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   fd_skid_reg_if.slave bus
);

   function automatic logic [2:0] imm_fmt(input logic [6:0] opcode);
      case (opcode)
         7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: imm_fmt = 3'b000;
         7'b0100011:                                     imm_fmt = 3'b001;
         7'b1100011:                                     imm_fmt = 3'b010;
         7'b1101111:                                     imm_fmt = 3'b011;
         7'b0110111, 7'b0010111:                         imm_fmt = 3'b100;
         default:                                        imm_fmt = 3'b000;
      endcase
   endfunction

   logic [1:0]      count;
   logic [1:0]      count_next;
   logic            f_ready;
   logic            vld_p0;
   logic            push;
   logic            pop;
   logic [ILEN-1:0] instr_p0, instr_p1;
   logic [XLEN-1:0] pc_p0, pc_p1;
   logic [XLEN-1:0] pc4_p0, pc4_p1;

   assign vld_p0 = (count != 2'd0);
   assign push   = bus.f_valid & f_ready;
   assign pop    = vld_p0 & bus.d_ready;

   always_comb begin
      count_next = count;
      if (bus.flush) begin
         count_next = 2'd0;
      end else begin
         case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
         endcase
      end
   end

   // Control state: occupancy and the registered ready
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count   <= 2'd0;
         f_ready <= 1'b1;
      end else begin
         count   <= count_next;
         f_ready <= (count_next != 2'd2);
      end
   end

   // Entry storage is unreset: every output is masked by vld_p0, so stale contents never escape
   always_ff @(posedge clk) begin
      if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
         instr_p0 <= bus.f_instr;
         pc_p0    <= bus.f_pc;
         pc4_p0   <= bus.f_pc4;
      end else if (push && count == 2'd1) begin
         instr_p1 <= bus.f_instr;
         pc_p1    <= bus.f_pc;
         pc4_p1   <= bus.f_pc4;
      end else if (pop && count == 2'd2) begin
         instr_p0 <= instr_p1;
         pc_p0    <= pc_p1;
         pc4_p0   <= pc4_p1;
      end
   end

   assign bus.f_ready  = f_ready;
   assign bus.d_valid  = vld_p0;
   assign bus.d_instr  = vld_p0 ? instr_p0 : NOP;
   assign bus.d_pc     = vld_p0 ? pc_p0 : '0;
   assign bus.d_pc4    = vld_p0 ? pc4_p0 : '0;
   assign bus.d_immsrc = vld_p0 ? imm_fmt(instr_p0[6:0]) : 3'b000;

endmodule
